// File: rtl/segasys1_prgrom_arb.sv
// Program-ROM read-port arbiter: round-robin between two requesters, fixed ROM
// latency, registered data with a one-cycle ack, grants frozen during download.
module segasys1_prgrom_arb #(
    parameter int AW      = 15,
    parameter int DW      = 8,
    parameter int ROM_LAT = 1   // legal range 1..7; the 3-bit counter cannot hold more
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic [AW-1:0] a_ad,
    output logic          a_ack,
    output logic [DW-1:0] a_dt,
    input  logic          b_req,
    input  logic [AW-1:0] b_ad,
    output logic          b_ack,
    output logic [DW-1:0] b_dt,
    input  logic          dl_busy,
    output logic [AW-1:0] rom_ad,
    input  logic [DW-1:0] rom_dt,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LAT3 = 3'(ROM_LAT);

    state_t     state;
    logic       gnt;        // 0 = A, 1 = B
    logic       last_gnt;   // 0 = A, 1 = B
    logic [2:0] cnt;

    logic a_elig;
    logic b_elig;
    logic pick_b;

    // A requester whose ack is high this cycle is still holding req from the
    // finished access, so it must sit out one cycle to avoid a double grant.
    always_comb begin
        a_elig = a_req && !a_ack && !dl_busy;
        b_elig = b_req && !b_ack && !dl_busy;
        pick_b = b_elig && (!a_elig || !last_gnt);
    end

    // NOTE: all state and outputs update with <= so every read in this block
    // sees the pre-edge value, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= '0;
            rom_ad   <= '0;
            a_dt     <= '0;
            b_dt     <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_elig || b_elig) begin
                        rom_ad   <= pick_b ? b_ad : a_ad;
                        gnt      <= pick_b;
                        last_gnt <= pick_b;
                        cnt      <= LAT3;
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        if (gnt) begin
                            b_dt  <= rom_dt;
                            b_ack <= 1'b1;
                        end else begin
                            a_dt  <= rom_dt;
                            a_ack <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segasys1_prgrom_arb.sv
// Directed bench for segasys1_prgrom_arb: one instance at ROM_LAT=1 and one at
// ROM_LAT=3, each fed by a ROM model returning ad[7:0]^8'h5A.
module tb_segasys1_prgrom_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    int          checks = 0;
    int          errors = 0;

    // instance with ROM_LAT=1
    logic        a_req, b_req, dl_busy;
    logic [14:0] a_ad, b_ad, rom_ad;
    logic        a_ack, b_ack, busy;
    logic [7:0]  a_dt, b_dt, rom_dt;

    // instance with ROM_LAT=3
    logic        a_req3, b_req3, dl_busy3;
    logic [14:0] a_ad3, b_ad3, rom_ad3;
    logic        a_ack3, b_ack3, busy3;
    logic [7:0]  a_dt3, b_dt3, rom_dt3;
    logic [7:0]  p0, p1;

    always #5 clk = ~clk;

    segasys1_prgrom_arb #(.AW(15), .DW(8), .ROM_LAT(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_ad(a_ad), .a_ack(a_ack), .a_dt(a_dt),
        .b_req(b_req), .b_ad(b_ad), .b_ack(b_ack), .b_dt(b_dt),
        .dl_busy(dl_busy), .rom_ad(rom_ad), .rom_dt(rom_dt), .busy(busy)
    );

    segasys1_prgrom_arb #(.AW(15), .DW(8), .ROM_LAT(3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req3), .a_ad(a_ad3), .a_ack(a_ack3), .a_dt(a_dt3),
        .b_req(b_req3), .b_ad(b_ad3), .b_ack(b_ack3), .b_dt(b_dt3),
        .dl_busy(dl_busy3), .rom_ad(rom_ad3), .rom_dt(rom_dt3), .busy(busy3)
    );

    // ROM models: data valid exactly ROM_LAT cycles after the address changes
    always @(posedge clk) rom_dt <= rom_ad[7:0] ^ 8'h5A;
    always @(posedge clk) begin
        p0      <= rom_ad3[7:0] ^ 8'h5A;
        p1      <= p0;
        rom_dt3 <= p1;
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        a_req = 0; b_req = 0; dl_busy = 0; a_ad = '0; b_ad = '0;
        a_req3 = 0; b_req3 = 0; dl_busy3 = 0; a_ad3 = '0; b_ad3 = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rom_ad, a_dt, b_dt, a_ack, b_ack, busy} !== '0) begin
            errors++;
            $display("FAIL reset_lat1: rom_ad=%h a_dt=%h b_dt=%h a_ack=%b b_ack=%b busy=%b, expected all 0",
                     rom_ad, a_dt, b_dt, a_ack, b_ack, busy);
        end
        checks++;
        if ({rom_ad3, a_dt3, b_dt3, a_ack3, b_ack3, busy3} !== '0) begin
            errors++;
            $display("FAIL reset_lat3: rom_ad=%h a_dt=%h b_dt=%h a_ack=%b b_ack=%b busy=%b, expected all 0",
                     rom_ad3, a_dt3, b_dt3, a_ack3, b_ack3, busy3);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (rom_ad !== 15'h1234 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_rom_ad c%0d: rom_ad=%h busy=%b, expected 1234 1", c, rom_ad, busy);
                end
            end
            if (c >= 1) begin
                checks++;
                if (a_ack !== (c == 3) || b_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL single_ack c%0d: a_ack=%b b_ack=%b, expected %b 0", c, a_ack, b_ack, c == 3);
                end
            end
            if (c == 3) begin
                checks++;
                if (a_dt !== 8'h6E || b_dt !== 8'h00) begin
                    errors++;
                    $display("FAIL single_dt: a_dt=%h b_dt=%h, expected 6e 00", a_dt, b_dt);
                end
            end
            if (c == 0) begin a_req = 1; a_ad = 15'h1234; end
            if (c == 3) a_req = 0;
        end
    endtask

    task automatic test_both();
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (a_ack !== (c == 3) || b_ack !== (c == 6)) begin
                    errors++;
                    $display("FAIL both_ack c%0d: a_ack=%b b_ack=%b, expected %b %b", c, a_ack, b_ack, c == 3, c == 6);
                end
            end
            if (c == 3 || c == 6) begin
                checks++;
                if (a_dt !== 8'h4A || b_dt !== ((c == 6) ? 8'h7A : 8'h00)) begin
                    errors++;
                    $display("FAIL both_dt c%0d: a_dt=%h b_dt=%h, expected 4a %h", c, a_dt, b_dt, (c == 6) ? 8'h7A : 8'h00);
                end
            end
            if (c == 4) begin
                checks++;
                if (rom_ad !== 15'h0020) begin
                    errors++;
                    $display("FAIL both_rom_ad: rom_ad=%h, expected 0020", rom_ad);
                end
            end
            if (c == 0) begin a_req = 1; a_ad = 15'h0010; b_req = 1; b_ad = 15'h0020; end
            if (c == 3) a_req = 0;
            if (c == 6) b_req = 0;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c <= 41; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (a_ack !== (c % 6 == 3) || b_ack !== (c % 6 == 0)) begin
                    errors++;
                    $display("FAIL b2b_ack c%0d: a_ack=%b b_ack=%b, expected %b %b", c, a_ack, b_ack, c % 6 == 3, c % 6 == 0);
                end
            end
            if (c >= 3 && c % 3 == 0) begin
                checks++;
                if (a_dt !== 8'h4B || (c >= 6 && b_dt !== 8'h78)) begin
                    errors++;
                    $display("FAIL b2b_dt c%0d: a_dt=%h b_dt=%h, expected 4b 78", c, a_dt, b_dt);
                end
            end
            if (c == 0) begin a_req = 1; a_ad = 15'h0011; b_req = 1; b_ad = 15'h0022; end
            if (c == 39) begin a_req = 0; b_req = 0; end
        end
    endtask

    task automatic test_dl_busy();
        apply_reset();
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 10) begin
                checks++;
                if (busy !== 1'b0 || rom_ad !== 15'h0000 || a_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL dl_block c%0d: busy=%b rom_ad=%h a_ack=%b, expected 0 0000 0", c, busy, rom_ad, a_ack);
                end
            end
            if (c == 11) begin
                checks++;
                if (rom_ad !== 15'h0100 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL dl_grant: rom_ad=%h busy=%b, expected 0100 1", rom_ad, busy);
                end
            end
            if (c >= 11) begin
                checks++;
                if (a_ack !== (c == 13)) begin
                    errors++;
                    $display("FAIL dl_ack c%0d: a_ack=%b, expected %b", c, a_ack, c == 13);
                end
            end
            if (c == 13) begin
                checks++;
                if (a_dt !== 8'h5A) begin
                    errors++;
                    $display("FAIL dl_dt: a_dt=%h, expected 5a", a_dt);
                end
            end
            if (c == 0) begin dl_busy = 1; a_req = 1; a_ad = 15'h0100; end
            if (c == 10) dl_busy = 0;
            if (c == 13) a_req = 0;
        end

        // download starts while an access is already in flight
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (a_ack !== (c == 3) || busy !== (c <= 2)) begin
                    errors++;
                    $display("FAIL dl_mid c%0d: a_ack=%b busy=%b, expected %b %b", c, a_ack, busy, c == 3, c <= 2);
                end
            end
            if (c == 3) begin
                checks++;
                if (a_dt !== 8'h69) begin
                    errors++;
                    $display("FAIL dl_mid_dt: a_dt=%h, expected 69", a_dt);
                end
            end
            if (c == 0) begin a_req = 1; a_ad = 15'h0033; end
            if (c == 1) dl_busy = 1;
            if (c == 8) begin a_req = 0; dl_busy = 0; end
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_busy: busy=%b, expected 1", busy);
                end
            end
            if (c == 2) begin
                checks++;
                if ({rom_ad, a_dt, b_dt, a_ack, b_ack, busy} !== '0) begin
                    errors++;
                    $display("FAIL abort_clear: rom_ad=%h a_dt=%h b_dt=%h a_ack=%b b_ack=%b busy=%b, expected all 0",
                             rom_ad, a_dt, b_dt, a_ack, b_ack, busy);
                end
            end
            if (c >= 3) begin
                checks++;
                if (a_ack !== (c == 5)) begin
                    errors++;
                    $display("FAIL abort_ack c%0d: a_ack=%b, expected %b", c, a_ack, c == 5);
                end
            end
            if (c == 5) begin
                checks++;
                if (a_dt !== 8'h1E) begin
                    errors++;
                    $display("FAIL abort_regrant_dt: a_dt=%h, expected 1e", a_dt);
                end
            end
            if (c == 0) begin a_req = 1; a_ad = 15'h0044; end
            if (c == 1) reset_n = 0;
            if (c == 2) reset_n = 1;
            if (c == 5) a_req = 0;
        end
    endtask

    task automatic test_lat3();
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (b_ack3 !== (c == 5) || a_ack3 !== 1'b0 || a_dt3 !== 8'h00) begin
                    errors++;
                    $display("FAIL lat3_ack c%0d: b_ack=%b a_ack=%b a_dt=%h, expected %b 0 00", c, b_ack3, a_ack3, a_dt3, c == 5);
                end
            end
            if (c == 5) begin
                checks++;
                if (b_dt3 !== 8'hA5) begin
                    errors++;
                    $display("FAIL lat3_dt: b_dt=%h, expected a5", b_dt3);
                end
            end
            if (c == 0) begin b_req3 = 1; b_ad3 = 15'h7FFF; end
            if (c == 5) b_req3 = 0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_dl_busy();
        test_reset_abort();
        test_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
